// File: rtl/ones_count_pkg.sv
// Shared types and width helpers for the popcount / ones-count accumulation path.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ones_count_pkg;

   // Frame FSM states of the accumulator
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Width of a single-word ones count able to represent 0..n inclusive
   function automatic int cw_of(input int n);
      return $clog2(n) + 1;
   endfunction

   // Width of a frame total able to represent 0..n*f inclusive
   function automatic int tw_of(input int n, input int f);
      return $clog2(n * f + 1);
   endfunction

endpackage

// File: rtl/ones_count_accum.sv
// Accumulates clamped per-word ones counts over a frame of frameLen beats; reports total/max/threshold flags.
// Latency: results valid 1 cycle after the last accepted beat; held until the out_valid/out_ready handshake.
// Backpressure: in_ready only in ACCUM; in DONE the block stalls until out_ready, accepting no new beats.
module ones_count_accum
   import ones_count_pkg::*;
#(
   parameter  int inCount  = 16,
   parameter  int frameLen = 8,
   localparam int CW       = cw_of(inCount),
   localparam int TW       = tw_of(inCount, frameLen)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [TW-1:0] threshold,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] count_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [TW-1:0] total,
   output logic [CW-1:0] max_count,
   output logic          over_thresh,
   output logic          clamped,
   output logic          busy
);

   localparam int            BW        = $clog2(frameLen);
   localparam logic [BW-1:0] LAST_BEAT = BW'(frameLen - 1);
   localparam logic [CW-1:0] CLAMP_MAX = CW'(inCount);

   state_t        state_q, state_d;
   logic [TW-1:0] total_q, total_d;
   logic [CW-1:0] max_q, max_d;
   logic          clamped_q, clamped_d;
   logic          over_q, over_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [TW-1:0] thresh_q, thresh_d;

   logic          open_frame;
   logic [CW-1:0] cnt_clamped;
   logic [TW-1:0] sum_next;

   // Next-state and datapath: beats fold into the running results; a new frame clears and samples threshold
   always_comb begin
      state_d     = state_q;
      total_d     = total_q;
      max_d       = max_q;
      clamped_d   = clamped_q;
      over_d      = over_q;
      beat_d      = beat_q;
      thresh_d    = thresh_q;
      open_frame  = 1'b0;

      cnt_clamped = (count_in > CLAMP_MAX) ? CLAMP_MAX : count_in;
      sum_next    = total_q + TW'(cnt_clamped);

      case (state_q)
         IDLE: begin
            if (start) begin
               open_frame = 1'b1;
            end
         end
         ACCUM: begin
            // abort wins over a beat presented in the same cycle
            if (abort) begin
               state_d = IDLE;
            end else if (in_valid) begin
               total_d = sum_next;
               if (cnt_clamped > max_q) begin
                  max_d = cnt_clamped;
               end
               if (count_in > CLAMP_MAX) begin
                  clamped_d = 1'b1;
               end
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  // compare against the total that includes this final beat
                  over_d  = (sum_next > thresh_q);
                  state_d = DONE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               if (start) begin
                  open_frame = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (open_frame) begin
         state_d   = ACCUM;
         total_d   = '0;
         max_d     = '0;
         clamped_d = 1'b0;
         over_d    = 1'b0;
         beat_d    = '0;
         thresh_d  = threshold;
      end
   end

   // State and result registers; reset drops any frame in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         total_q   <= '0;
         max_q     <= '0;
         clamped_q <= 1'b0;
         over_q    <= 1'b0;
         beat_q    <= '0;
         thresh_q  <= '0;
      end else begin
         state_q   <= state_d;
         total_q   <= total_d;
         max_q     <= max_d;
         clamped_q <= clamped_d;
         over_q    <= over_d;
         beat_q    <= beat_d;
         thresh_q  <= thresh_d;
      end
   end

   assign in_ready    = (state_q == ACCUM);
   assign busy        = (state_q == ACCUM);
   assign out_valid   = (state_q == DONE);
   assign total       = total_q;
   assign max_count   = max_q;
   assign over_thresh = over_q;
   assign clamped     = clamped_q;

endmodule

// File: doc/ones_count_accum.md
ONES_COUNT_ACCUM -- requirements
Module: ones_count_accum

Interface
REQ-001 SHALL have parameter inCount, default 16: width of the upstream popcount input vector.
REQ-002 SHALL have parameter frameLen, default 8: number of count beats per frame; legal range is at least 2.
REQ-003 SHALL derive the localparam CW = $clog2(inCount)+1 (count width) and TW = $clog2(inCount*frameLen+1) (total width).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a frame.
REQ-007 abort  input  1  discard the current frame.
REQ-008 threshold  input  TW  compare level, sampled at frame start.
REQ-009 in_valid  input  1  count_in is valid.
REQ-010 in_ready  output  1  block accepts count_in.
REQ-011 count_in  input  CW  ones count of one word, from the upstream popcount stage.
REQ-012 out_valid  output  1  frame results are valid.
REQ-013 out_ready  input  1  consumer accepts the results.
REQ-014 total  output  TW  sum of the clamped counts in the frame.
REQ-015 max_count  output  CW  largest clamped count in the frame.
REQ-016 over_thresh  output  1  total > sampled threshold.
REQ-017 clamped  output  1  sticky: at least one beat in the frame exceeded inCount.
REQ-018 busy  output  1  high in the ACCUM state.

Function
REQ-019 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-020 IDLE: in_ready=0, out_valid=0; on start SHALL clear total, max_count, clamped and the beat counter, sample threshold, and go to ACCUM.
REQ-021 ACCUM: in_ready=1; a beat is accepted only when in_valid and in_ready are both high.
REQ-022 On each accepted beat, the block SHALL add min(count_in, inCount) to total, update max_count, increment the beat counter, and set clamped if count_in > inCount.
REQ-023 A beat accepted when the beat counter equals frameLen-1 SHALL move the FSM to DONE; out_valid rises the next cycle, giving a latency of 1 cycle from the last accepted beat.
REQ-024 In DONE, in_ready SHALL be 0, out_valid SHALL be 1, and all results SHALL be held stable until out_valid and out_ready are both high.
REQ-025 On the DONE handshake, the FSM SHALL go to IDLE; if start is high in the same cycle, it SHALL instead go directly to ACCUM with the clearing and sampling of REQ-020.
REQ-026 Cycles with in_valid low SHALL not alter state; gaps between beats are unlimited.
REQ-027 abort in ACCUM SHALL return the FSM to IDLE next cycle with no out_valid; the beat presented in the abort cycle SHALL not be accepted.
REQ-028 abort SHALL be ignored in IDLE and DONE; start SHALL be ignored in ACCUM and, except as in REQ-025, in DONE.
REQ-029 over_thresh SHALL be registered when DONE is entered and SHALL use the final total, including the last beat.
REQ-030 Arithmetic SHALL be unsigned; total cannot overflow TW by construction.
REQ-031 The results SHALL retain the last frame's values in IDLE, until the next start clears them.

Reset
REQ-032 While rst_n is low: state=IDLE, and in_ready, out_valid, total, max_count, over_thresh, clamped, busy, the beat counter and the sampled threshold are all 0, without waiting for a clock edge.
REQ-033 A reset asserted mid-frame SHALL discard the frame; the first start after release SHALL behave as REQ-020.

Structure
REQ-034 Package ones_count_pkg SHALL hold the state enum (IDLE, ACCUM, DONE) and the CW/TW width functions shared with the upstream popcount stage.
REQ-035 FSM and datapath SHALL live in one module; no sub-module is required.
REQ-036 All outputs SHALL be registered or decoded directly from the state register.

Verification (inCount=16, frameLen=4)
REQ-037 Nominal frame: start with threshold=20, then beats 3,16,0,7 back-to-back -> out_valid 1 cycle after the 4th beat; total=26, max_count=16, over_thresh=1, clamped=0.
REQ-038 Backpressure: hold out_ready low for 5 cycles in DONE -> results stable, in_ready=0, in_valid pulses ignored; handshake -> IDLE.
REQ-039 Clamp and gaps: beats 31,1,1,1 with 3-cycle idle gaps, threshold=20 -> total=19, max_count=16, clamped=1, over_thresh=0.
REQ-040 Abort after 2 beats -> IDLE with no out_valid; the next frame 1,1,1,1 -> total=4 (no residue).
REQ-041 Reset asserted asynchronously mid-ACCUM -> all outputs 0 before the next clock edge; after release, start plus 4 beats of 2 -> total=8.
REQ-042 Back-to-back frames: start in the DONE handshake cycle -> ACCUM directly; the second frame's results are independent of the first.
